// File: rtl/exp_pkg.sv
// Shared types and default constants for the exposure controller.
package exp_pkg;
   typedef enum logic [1:0] {LOCK, IDLE, PRESS, REPEAT} state_e;
   typedef enum logic {INC, DEC} dir_e;
   localparam int W_DEF    = 5;
   localparam int MIN_DEF  = 2;
   localparam int MAX_DEF  = 30;
   localparam int INIT_DEF = 15;
   localparam int STEP_DEF = 1;
   localparam int HOLD_DEF = 8;
   localparam int RATE_DEF = 2;
endpackage

// File: rtl/exp_repeat_timer.sv
// Auto-repeat timer: fires at held cycle HOLD, then every RATE cycles.
module exp_repeat_timer #(
   parameter int HOLD = 8,
   parameter int RATE = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic fire_o
);
   localparam int MX = (HOLD > RATE) ? HOLD : RATE;
   localparam int CW = $clog2(MX + 1);

   // cnt_q holds the held-cycle index minus one
   logic [CW-1:0] cnt_q;
   logic          rep_q;

   assign fire_o = enable_i && !clear_i &&
                   (rep_q ? (cnt_q == CW'(RATE - 1))
                          : (cnt_q == CW'(HOLD - 1)));

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else if (enable_i) begin
         if (fire_o) begin
            cnt_q <= '0;
            rep_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end
endmodule

// File: rtl/exp_ctrl.sv
// Exposure up/down controller with saturating steps and direct load.
// Auto-repeat on long press is enabled by defining EXP_AUTOREPEAT_EN.
module exp_ctrl
   import exp_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int MIN  = MIN_DEF,
   parameter int MAX  = MAX_DEF,
   parameter int INIT = INIT_DEF,
   parameter int STEP = STEP_DEF,
   parameter int HOLD = HOLD_DEF,
   parameter int RATE = RATE_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q,
   output logic         at_min,
   output logic         at_max,
   output logic         changed
);
   if (!(MIN <= INIT && INIT <= MAX && MAX < (1 << W) &&
         STEP >= 1 && HOLD >= 1 && RATE >= 1)) begin : g_bad_cfg
      $error("exp_ctrl: illegal parameter set");
   end

   localparam logic [W:0] MINX  = (W+1)'(MIN);
   localparam logic [W:0] MAXX  = (W+1)'(MAX);
   localparam logic [W:0] INITX = (W+1)'(INIT);
   localparam logic [W:0] STEPX = (W+1)'(STEP);

   state_e       state_q, state_d;
   dir_e         dir_q, dir_d;
   logic [W-1:0] q_q, q_d;
   logic         at_min_q, at_max_q, changed_q;
   logic         held, other, step;
   logic [W:0]   q_x, sum, diff, up, dn, lv, lv_c, nxt;

   assign held  = (dir_q == INC) ? inc : dec;
   assign other = (dir_q == INC) ? dec : inc;

`ifdef EXP_AUTOREPEAT_EN
   logic fire;

   exp_repeat_timer #(
      .HOLD(HOLD),
      .RATE(RATE)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (!(state_q == PRESS || state_q == REPEAT)),
      .enable_i(held),
      .fire_o  (fire)
   );
`endif

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      step    = 1'b0;
      unique case (state_q)
         LOCK: if (!inc && !dec) state_d = IDLE;
         IDLE: begin
            if (inc) begin
               state_d = PRESS;
               dir_d   = INC;
               step    = 1'b1;
            end else if (dec) begin
               state_d = PRESS;
               dir_d   = DEC;
               step    = 1'b1;
            end
         end
         PRESS, REPEAT: begin
            // other button still down: wait for full release first
            if (!held) state_d = other ? LOCK : IDLE;
`ifdef EXP_AUTOREPEAT_EN
            else if (fire) begin
               state_d = REPEAT;
               step    = 1'b1;
            end
`endif
         end
         default: state_d = LOCK;
      endcase
   end

   always_comb begin
      q_x  = {1'b0, q_q};
      sum  = q_x + STEPX;
      diff = q_x - STEPX;
      up   = (sum > MAXX) ? MAXX : sum;
      dn   = (diff[W] || diff < MINX) ? MINX : diff;
      lv   = {1'b0, load_val};
      lv_c = (lv < MINX) ? MINX : ((lv > MAXX) ? MAXX : lv);
      nxt  = q_x;
      if (load)                          nxt = lv_c;
      else if (q_x < MINX || q_x > MAXX) nxt = INITX;
      else if (step)                     nxt = (dir_d == INC) ? up : dn;
      q_d  = nxt[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOCK;
         dir_q     <= INC;
         q_q       <= W'(INIT);
         at_min_q  <= (INIT == MIN);
         at_max_q  <= (INIT == MAX);
         changed_q <= 1'b0;
      end else begin
         state_q   <= load ? LOCK : state_d;
         dir_q     <= dir_d;
         q_q       <= q_d;
         at_min_q  <= (q_d == W'(MIN));
         at_max_q  <= (q_d == W'(MAX));
         changed_q <= (q_d != q_q);
      end
   end

   assign q       = q_q;
   assign at_min  = at_min_q;
   assign at_max  = at_max_q;
   assign changed = changed_q;
endmodule

// File: tb/tb_exp_ctrl.sv
// Directed bench for exp_ctrl; a STEP=4 copy shares the stimulus.
module tb_exp_ctrl;
   logic       clk, reset, inc, dec, load;
   logic [4:0] load_val;
   logic [4:0] q, q4;
   logic       at_min, at_max, changed;
   logic       at_min4, at_max4, changed4;
   int         n_chk, n_err, cnt;

   exp_ctrl u_dut (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec),
      .load(load), .load_val(load_val), .q(q),
      .at_min(at_min), .at_max(at_max), .changed(changed)
   );

   exp_ctrl #(.STEP(4)) u_dut4 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec),
      .load(load), .load_val(load_val), .q(q4),
      .at_min(at_min4), .at_max(at_max4), .changed(changed4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v);
      load = 1'b1; load_val = 5'(v); tick();
      load = 1'b0; tick();
   endtask

   function automatic int exp36(input int e);
`ifdef EXP_AUTOREPEAT_EN
      if (e < 8) return 14;
      if (e < 10) return 13;
      if (e < 12) return 12;
      return 11;
`else
      return (e >= 0) ? 14 : 15;
`endif
   endfunction

   initial begin
      n_chk = 0; n_err = 0;
      reset = 1'b1; inc = 1'b0; dec = 1'b0;
      load = 1'b0; load_val = '0;
      tick(); tick();
      chk("rst_q", q, 15);
      chk("rst_min", at_min, 0);
      chk("rst_max", at_max, 0);
      chk("rst_chg", changed, 0);

      inc = 1'b1; tick();
      reset = 1'b0; tick(); tick(); tick();
      chk("held_rst_q", q, 15);
      inc = 1'b0; tick();
      inc = 1'b1; tick();
      chk("repress_q", q, 16);
      chk("repress_chg", changed, 1);
      inc = 1'b0; tick();
      chk("release_chg", changed, 0);

      do_load(15);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         inc = 1'b1; tick(); cnt += changed;
         inc = 1'b0; tick(); cnt += changed;
      end
      chk("sat_q", q, 30);
      chk("sat_max", at_max, 1);
      chk("sat_pulses", cnt, 15);

      do_load(15);
      dec = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         tick();
         if (e == 0 || e == 7 || e == 8 || e == 10 || e == 12)
            chk($sformatf("hold_e%0d", e), q, exp36(e));
      end
      dec = 1'b0; tick();
      chk("hold_rel", q, exp36(12));
      tick();

      load = 1'b1; load_val = 5'd31; tick();
      chk("ld31_q", q, 30);
      chk("ld31_max", at_max, 1);
      load_val = 5'd0; tick();
      chk("ld0_q", q, 2);
      chk("ld0_min", at_min, 1);
      load_val = 5'd20; inc = 1'b1; tick();
      chk("ld_inc_q", q, 20);
      load = 1'b0; tick();
      chk("ld_lock_q", q, 20);
      inc = 1'b0; tick();

      do_load(15);
      inc = 1'b1; dec = 1'b1; tick();
      chk("both_q", q, 16);
      inc = 1'b0; tick(); tick();
      chk("dec_stay_q", q, 16);
      dec = 1'b0; tick();
      dec = 1'b1; tick();
      chk("dec_repress_q", q, 15);
      dec = 1'b0; tick();

      do_load(2);
      dec = 1'b1; tick();
      chk("min_sat_q", q, 2);
      chk("min_sat_chg", changed, 0);
      chk("min_sat_flag", at_min, 1);
      dec = 1'b0; tick();

      do_load(28);
      inc = 1'b1; tick();
      chk("s4_q", q4, 30);
      chk("s4_chg", changed4, 1);
      chk("s1_q", q, 29);
      inc = 1'b0; tick();
      inc = 1'b1; tick();
      chk("s4_q2", q4, 30);
      chk("s4_chg2", changed4, 0);
      chk("s4_max", at_max4, 1);
      chk("s1_q2", q, 30);
      inc = 1'b0; tick();

      load = 1'b1; load_val = 5'd3; reset = 1'b1; tick();
      chk("rst_ld_q", q, 15);
      chk("rst_ld_chg", changed, 0);
      load = 1'b0; reset = 1'b0; tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
